// File: rtl/acc_quant.sv
// acc_quant: accumulates num_ch partial sums on top of a bias, then rounds,
// shifts, optionally clamps negatives and saturates each group to OUT_W bits.
//   clk, rst                            clock, async active-high reset
//   start_i, stop_i                     enter RUN (latching config) / abandon group
//   cfg_num_ch, cfg_shift, cfg_relu     group size, right shift, negative clamp
//   bias_i                              signed bias preloaded into every group
//   vld_i, acc_i                        partial-sum input
//   busy_o                              high while in RUN
//   vld_o, data_o                       one-cycle result pulse and quantized value
//   err_o                               sticky: data arrived while idle
module acc_quant #(
  parameter int IN_W  = 20,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [7:0]       cfg_num_ch,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic [15:0]      bias_i,
  input  logic             vld_i,
  input  logic [IN_W-1:0]  acc_i,
  output logic             busy_o,
  output logic             vld_o,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  state_t                   state;
  logic [7:0]               last_q;
  logic [4:0]               shift_q;
  logic                     relu_q;
  logic signed [ACC_W-1:0]  bias_q;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               cnt;
  logic signed [ACC_W-1:0]  fin;
  logic                     fin_vld;

  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic [OUT_W-1:0]         quant;

  assign bias_ext = {{(ACC_W-16){bias_i[15]}}, bias_i};
  assign in_ext   = {{(ACC_W-IN_W){acc_i[IN_W-1]}}, acc_i};
  assign acc_sum  = acc + in_ext;
  assign busy_o   = (state == RUN);

  // shift_q/relu_q cannot change before fin drains: a restart needs stop then
  // start, which always lands after the output register has taken fin.
  always_comb begin
    rnd = '0;
    if (shift_q != 5'd0) begin
      rnd = (ACC_W+1)'(1) << (shift_q - 5'd1);
    end
    rnd_sum = {fin[ACC_W-1], fin} + rnd;
    shifted = rnd_sum >>> shift_q;
    if (relu_q && shifted[ACC_W]) begin
      shifted = '0;
    end
    if (shifted > SAT_HI) begin
      quant = SAT_HI[OUT_W-1:0];
    end else if (shifted < SAT_LO) begin
      quant = SAT_LO[OUT_W-1:0];
    end else begin
      quant = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      bias_q  <= '0;
      acc     <= '0;
      cnt     <= '0;
      fin     <= '0;
      fin_vld <= 1'b0;
      vld_o   <= 1'b0;
      data_o  <= '0;
      err_o   <= 1'b0;
    end else begin
      fin_vld <= 1'b0;
      vld_o   <= fin_vld;
      if (fin_vld) begin
        data_o <= quant;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            // Store N-1 so a count of 0 behaves as a group of one.
            last_q  <= (cfg_num_ch == 8'd0) ? 8'd0 : cfg_num_ch - 8'd1;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu;
            bias_q  <= bias_ext;
            acc     <= bias_ext;
            cnt     <= '0;
            err_o   <= 1'b0;
            state   <= RUN;
          end else if (vld_i) begin
            err_o <= 1'b1;
          end
        end
        RUN: begin
          if (stop_i) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (vld_i) begin
            if (cnt == last_q) begin
              fin     <= acc_sum;
              fin_vld <= 1'b1;
              acc     <= bias_q;
              cnt     <= '0;
            end else begin
              acc <= acc_sum;
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
